uart_tx_arbiter: RTL and testbench

- Shares one byte-wide UART transmitter between N_REQ requesters, e.g. a status reporter, a loopback echo fed by the receiver, and a debug dumper.
- Arbitration is packet-level round-robin. Once a requester is granted, it holds the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the uart_tx byte engine.
- Has one output register stage toward the transmitter.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide UART transmitter among N_REQ requesters.
// Optional UART_TX_ARB_PRIO_EN: requester 0 wins every arbitration it takes part in.
//
// state | meaning
// IDLE  | no owner; pick the next requester with a pending byte
// LOCK  | owner holds the transmitter; bytes accepted one at a time into the buffer
// DRAIN | packet ended (last byte or timeout); wait for the buffer to empty, then release
module uart_tx_arbiter #(
  parameter int          N_REQ   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IW-1:0]    r_gidx;
  logic [IW-1:0]    r_rr_ptr;
  logic [15:0]      r_cnt;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_timeout_err;

  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_try;
  logic             w_found;
  logic             w_own_valid;
  logic             w_own_last;
  logic [7:0]       w_own_data;
  logic             w_accept_ok;
  logic             w_hs;
  logic [IW-1:0]    w_rr_next;

  // First pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    w_pick  = '0;
    w_try   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_try = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req_valid[w_try]) begin
        w_found = 1'b1;
        w_pick  = w_try;
      end
    end
`ifdef UART_TX_ARB_PRIO_EN
    if (req_valid[0]) w_pick = '0;
`endif
  end

  assign w_own_valid = req_valid[r_gidx];
  assign w_own_last  = req_last[r_gidx];
  assign w_own_data  = req_data[{r_gidx, 3'b000} +: 8];

  // A byte is taken only into a strictly empty buffer.
  assign w_accept_ok = (r_state == LOCK) && !r_tx_valid;
  assign w_hs        = w_accept_ok && w_own_valid;
  assign req_ready   = {N_REQ{w_accept_ok}} & r_grant & req_valid;

  always_comb begin
    w_rr_next = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
`ifdef UART_TX_ARB_PRIO_EN
    if (r_gidx == '0) w_rr_next = r_rr_ptr;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (|req_valid) begin
            r_gidx  <= w_pick;
            r_grant <= N_REQ'(1) << w_pick;
            r_state <= LOCK;
          end
        end

        LOCK: begin
          if (w_hs) begin
            r_tx_data  <= w_own_data;
            r_tx_valid <= 1'b1;
            r_cnt      <= '0;
            if (w_own_last) r_state <= DRAIN;
          end else if (!w_own_valid && !r_tx_valid) begin
            if (r_cnt == TIMEOUT - 16'd1) begin
              r_timeout_err <= 1'b1;
              r_cnt         <= '0;
              r_state       <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end else begin
            r_cnt <= '0;
          end
        end

        DRAIN: begin
          r_cnt <= '0;
          if (!r_tx_valid) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_rr_next;
          end
        end

        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != IDLE) || r_tx_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive the inputs, a monitor
// pops expected {requester, byte} entries on every tx_valid&tx_ready transfer.
module tb_uart_tx_arbiter;
  localparam int          N   = 4;
  localparam logic [15:0] TMO = 16'd8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, busy, timeout_err;

  int checks = 0;
  int errors = 0;
  int tmo_seen = 0;

  logic [8:0]  src_mem [N][32];
  int          src_rd [N];
  int          src_wr [N];
  logic [10:0] sb_q [$];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (src_rd[i] != src_wr[i]);
      req_last[i]        = src_mem[i][src_rd[i] % 32][8];
      req_data[8*i +: 8] = src_mem[i][src_rd[i] % 32][7:0];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) src_rd[i] <= src_rd[i] + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_wr[r] % 32] = {l, d};
    src_wr[r] = src_wr[r] + 1;
  endtask

  task automatic expect_byte(input int r, input logic [7:0] d);
    sb_q.push_back({3'(r), d});
  endtask

  function automatic bit drained();
    for (int i = 0; i < N; i++)
      if (src_rd[i] != src_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (timeout_err) tmo_seen <= tmo_seen + 1;
    if (!rst && tx_valid && tx_ready) begin
      check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [10:0] e;
        e = sb_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e[7:0]));
        check("tx_owner", 32'(grant), 32'(4'b0001 << e[10:8]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < N; i++) src_wr[i] = src_rd[i];
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(sb_q.size() == 0 && !busy && drained()) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 1000), 32'd1);
  endtask

  task automatic wait_tx_valid(input string name);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(tx_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    int   idle;
    int   n;
    int   tmo0;
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single requester 1, two-byte packet, exact latency
    @(negedge clk);
    enq(1, 8'h55, 1'b0); enq(1, 8'hAA, 1'b1);
    expect_byte(1, 8'h55); expect_byte(1, 8'hAA);
    @(negedge clk);
    check("t1_grant_c1", 32'(grant), 32'h2);
    check("t1_ready_c1", 32'(req_ready), 32'h2);
    check("t1_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_tx_valid_c2", 32'(tx_valid), 32'd1);
    check("t1_tx_data_c2", 32'(tx_data), 32'h55);
    check("t1_ready_full_c2", 32'(req_ready), 32'd0);
    wait_done("t1_done");
    check("t1_grant_released", 32'(grant), 32'd0);

    // rr_ptr now 2: requester 2 beats requester 1
    @(negedge clk);
    enq(1, 8'h01, 1'b1); enq(2, 8'h02, 1'b1);
    expect_byte(2, 8'h02); expect_byte(1, 8'h01);
    wait_done("t1b_rr_done");

    // All four from reset: order 0,1,2,3 with no interleaving
    do_reset();
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      enq(r, 8'(16 * r + 1), 1'b0); enq(r, 8'(16 * r + 2), 1'b1);
      expect_byte(r, 8'(16 * r + 1)); expect_byte(r, 8'(16 * r + 2));
    end
    wait_done("t2_all4_done");

    // Backpressure
    do_reset();
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    enq(0, 8'hC3, 1'b0); enq(0, 8'h3C, 1'b1);
    expect_byte(0, 8'hC3); expect_byte(0, 8'h3C);
    wait_tx_valid("t3_first_valid");
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(tx_valid && tx_data == 8'hC3 && req_ready == '0 && grant == 4'b0001)) stable = 1'b0;
    end
    check("t3_hold_stable", 32'(stable), 32'd1);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_second_valid", 32'(tx_valid), 32'd1);
    check("t3_second_data", 32'(tx_data), 32'h3C);
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done("t3_done");

    // Timeout on requester 2, then requester 3 is serviced
    do_reset();
    @(negedge clk);
    enq(2, 8'h11, 1'b0); enq(3, 8'h33, 1'b1);
    expect_byte(2, 8'h11); expect_byte(3, 8'h33);
    tmo0 = tmo_seen;
    wait_tx_valid("t4_first_valid");
    idle = 0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
      if (!tx_valid) idle++;
    end
    check("t4_timeout_seen", 32'(timeout_err), 32'd1);
    check("t4_idle_cycles", 32'(idle), 32'd8);
    @(negedge clk);
    check("t4_pulse_width", 32'(timeout_err), 32'd0);
    wait_done("t4_done");
    check("t4_pulse_count", 32'(tmo_seen - tmo0), 32'd1);

    // Reset mid-packet
    do_reset();
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    enq(1, 8'h77, 1'b0); enq(1, 8'h78, 1'b1);
    wait_tx_valid("t5_valid_before_rst");
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("t5_async_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) src_wr[i] = src_rd[i];
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk);
    enq(1, 8'h99, 1'b1);
    expect_byte(1, 8'h99);
    wait_done("t5_after_rst_done");

    // Requesters 0 and 2 each with two single-byte packets
    do_reset();
    @(negedge clk);
    enq(0, 8'hA0, 1'b1); enq(0, 8'hA1, 1'b1);
    enq(2, 8'hB0, 1'b1); enq(2, 8'hB1, 1'b1);
`ifdef UART_TX_ARB_PRIO_EN
    expect_byte(0, 8'hA0); expect_byte(0, 8'hA1);
    expect_byte(2, 8'hB0); expect_byte(2, 8'hB1);
`else
    expect_byte(0, 8'hA0); expect_byte(2, 8'hB0);
    expect_byte(0, 8'hA1); expect_byte(2, 8'hB1);
`endif
    wait_done("t6_prio_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
